// File: rtl/reset_seq_pkg.sv
// Shared types and parameter defaults for the PLL-driven reset sequencer.
package reset_seq_pkg;

  // Sequencer states; the encoding is exported on state_dbg.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    FAULT     = 2'd3
  } seq_state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_HOLD_CYCLES   = 16;
  localparam int DEF_LOSS_W        = 8;

  // Larger of two sizes; the shared stable/hold counter is dimensioned from it.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// N-flop single-bit synchronizer with asynchronous clear to 0.
module bit_sync #(
  parameter int N = 2  // number of flops, at least 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  // Shift the asynchronous input through N flops; the last flop is the safe copy.
  // NOTE: clocked processes use non-blocking (<=) so every flop samples the pre-edge values of the others.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[N-2:0], i_d};
    end
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds the core in reset until the PLL lock flag has been
// stable for STABLE_CYCLES, re-sequences on lock loss or soft request, and
// counts lock losses (saturating).
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,    // min 2
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,  // min 2
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,    // min 1
  parameter int LOSS_W        = DEF_LOSS_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              locked,
  input  logic              soft_reset_req,
  output logic              sys_reset,
  output logic              ready,
  output logic [LOSS_W-1:0] loss_count,
  output logic [1:0]        state_dbg
);

  // One counter serves both STABILIZE and FAULT; it never exceeds the larger
  // terminal value minus one, so this width cannot overflow.
  localparam int CNT_W = $clog2(max_int(STABLE_CYCLES, HOLD_CYCLES));

  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [LOSS_W-1:0] LOSS_ONE    = LOSS_W'(1);
  localparam logic [LOSS_W-1:0] LOSS_MAX    = '1;

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [LOSS_W-1:0] r_loss;
  logic              w_loss_inc;
  logic              w_lock_s;
  logic              r_ready;
  logic              r_sys_reset;

  // The raw lock flag is asynchronous; only the synchronized copy is used below.
  bit_sync #(
    .N (SYNC_STAGES)
  ) u_lock_sync (
    .i_clock (clock),
    .i_reset (reset),
    .i_d     (locked),
    .o_q     (w_lock_s)
  );

  // Next-state, counter and loss-event decode.
  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_loss_inc  = 1'b0;
    case (r_state)
      WAIT_LOCK: begin
        w_cnt_nxt = '0;
        if (w_lock_s) begin
          w_state_nxt = STABILIZE;
        end
      end
      STABILIZE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_loss_inc  = 1'b1;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      RUN: begin
        w_cnt_nxt = '0;
        // A coincident soft request and lock loss is still only one loss.
        if (!w_lock_s || soft_reset_req) begin
          w_state_nxt = FAULT;
          w_loss_inc  = !w_lock_s;
        end
      end
      FAULT: begin
        // Leave after the full hold time whatever the lock flag says.
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Saturating lock-loss counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_loss <= '0;
    end else if (w_loss_inc && (r_loss != LOSS_MAX)) begin
      r_loss <= r_loss + LOSS_ONE;
    end
  end

  // Outputs registered from next-state so they change on the same edge as the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ready     <= 1'b0;
      r_sys_reset <= 1'b1;
    end else begin
      r_ready     <= (w_state_nxt == RUN);
      r_sys_reset <= (w_state_nxt != RUN);
    end
  end

  assign sys_reset  = r_sys_reset;
  assign ready      = r_ready;
  assign loss_count = r_loss;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: a cycle model pushes expected
// outputs into a scoreboard queue as inputs are driven; they are popped and
// compared one edge later. Directed checks cover latency and the hold times.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int HOLD   = 4;
  localparam int LW     = 2;
  localparam int LMAX   = (1 << LW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          locked;
  logic          soft_reset_req;
  logic          sys_reset;
  logic          ready;
  logic [LW-1:0] loss_count;
  logic [1:0]    state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0]    st;
    logic          rdy;
    logic [LW-1:0] loss;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state.
  logic [SYNC-1:0] m_sync;
  logic [1:0]      m_state;
  int              m_cnt;
  int              m_loss;

  always #5 clock = ~clock;

  reset_sequencer #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .HOLD_CYCLES   (HOLD),
    .LOSS_W        (LW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .locked         (locked),
    .soft_reset_req (soft_reset_req),
    .sys_reset      (sys_reset),
    .ready          (ready),
    .loss_count     (loss_count),
    .state_dbg      (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_step();
    logic ls;
    if (reset) begin
      m_sync  = '0;
      m_state = 2'd0;
      m_cnt   = 0;
      m_loss  = 0;
    end else begin
      ls = m_sync[SYNC-1];
      case (m_state)
        2'd0: begin
          m_cnt = 0;
          if (ls) m_state = 2'd1;
        end
        2'd1: begin
          if (!ls) begin
            m_state = 2'd0;
            m_cnt   = 0;
            if (m_loss < LMAX) m_loss++;
          end else if (m_cnt == STABLE - 1) begin
            m_state = 2'd2;
            m_cnt   = 0;
          end else begin
            m_cnt++;
          end
        end
        2'd2: begin
          if (!ls || soft_reset_req) begin
            m_state = 2'd3;
            m_cnt   = 0;
            if (!ls && m_loss < LMAX) m_loss++;
          end
        end
        default: begin
          if (m_cnt == HOLD - 1) begin
            m_state = 2'd0;
            m_cnt   = 0;
          end else begin
            m_cnt++;
          end
        end
      endcase
      m_sync = {m_sync[SYNC-2:0], locked};
    end
  endtask

  // One clock: push expectation, take the edge, pop and compare 1 ns later.
  task automatic cycle();
    exp_t e;
    model_step();
    e.st   = m_state;
    e.rdy  = (m_state == 2'd2);
    e.loss = LW'(m_loss);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    check("sb_state", state_dbg, e.st);
    check("sb_ready", ready, e.rdy);
    check("sb_sys_reset", sys_reset, !e.rdy);
    check("sb_loss", loss_count, e.loss);
  endtask

  // Clock until state_dbg reaches tgt; an expired budget is a failed check.
  task automatic wait_state(input logic [1:0] tgt, input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc; i++) begin
      cycle();
      if (state_dbg == tgt) return;
    end
    check(tag, state_dbg, tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset          = 1'b1;
    locked         = 1'b0;
    soft_reset_req = 1'b0;
    #2;
    check("rst_sys_reset", sys_reset, 1);
    check("rst_ready", ready, 0);
    check("rst_state", state_dbg, 0);
    check("rst_loss", loss_count, 0);
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    check("no_release_without_lock", sys_reset, 1);

    // Power-up: count edges from the first one that samples locked=1
    // (that edge counted as number 1) until sys_reset falls.
    locked = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (sys_reset && n < 40);
    check("powerup_latency", n, SYNC + STABLE + 1);
    check("powerup_ready", ready, 1);
    check("powerup_state", state_dbg, 2);

    // Soft request coinciding with synchronized lock loss: one increment.
    locked = 1'b0;
    repeat (SYNC) cycle();
    check("coinc_still_run", state_dbg, 2);
    soft_reset_req = 1'b1;
    cycle();
    soft_reset_req = 1'b0;
    check("coinc_state", state_dbg, 3);
    check("coinc_loss", loss_count, 1);
    n = 1;
    while (state_dbg == 2'd3 && n < 20) begin
      cycle();
      n++;
    end
    check("coinc_fault_len", n, HOLD + 1);
    check("coinc_after_fault", state_dbg, 0);
    locked = 1'b1;
    wait_state(2'd2, 40, "coinc_relock_timeout");

    // Soft reset alone: FAULT for HOLD cycles, no loss counted.
    repeat (2) cycle();
    soft_reset_req = 1'b1;
    cycle();
    soft_reset_req = 1'b0;
    check("soft_state", state_dbg, 3);
    check("soft_sys_reset", sys_reset, 1);
    n = 1;
    while (state_dbg == 2'd3 && n < 20) begin
      cycle();
      n++;
    end
    check("soft_fault_len", n - 1, HOLD);
    wait_state(2'd2, 40, "soft_restab_timeout");
    check("soft_loss_unchanged", loss_count, 1);

    // Lock loss in RUN.
    locked = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!sys_reset && n < 20);
    check("runloss_within", (n <= SYNC + 1), 1);
    check("runloss_state", state_dbg, 3);
    check("runloss_loss", loss_count, 2);
    n = 1;
    while (state_dbg == 2'd3 && n < 20) begin
      cycle();
      n++;
    end
    check("runloss_fault_len", n - 1, HOLD);

    // Glitch in STABILIZE after 5 stable cycles, then a full recount.
    locked = 1'b1;
    wait_state(2'd1, 20, "glitch_stab_timeout");
    repeat (4) cycle();
    check("glitch_pre_state", state_dbg, 1);
    locked = 1'b0;
    repeat (3) cycle();
    check("glitch_state", state_dbg, 0);
    check("glitch_loss", loss_count, 3);
    locked = 1'b1;
    wait_state(2'd1, 20, "glitch_restab_timeout");
    n = 1;
    while (state_dbg == 2'd1 && n < 40) begin
      cycle();
      n++;
    end
    check("glitch_recount", n - 1, STABLE);
    check("glitch_run", state_dbg, 2);

    // Reset mid-STABILIZE discards progress.
    locked = 1'b0;
    wait_state(2'd0, 20, "midstab_drop_timeout");
    locked = 1'b1;
    wait_state(2'd1, 20, "midstab_stab_timeout");
    repeat (3) cycle();
    reset = 1'b1;
    repeat (2) cycle();
    check("midstab_state", state_dbg, 0);
    check("midstab_loss", loss_count, 0);
    reset = 1'b0;
    wait_state(2'd1, 20, "midstab_restab_timeout");
    n = 1;
    while (state_dbg == 2'd1 && n < 40) begin
      cycle();
      n++;
    end
    check("midstab_full_count", n - 1, STABLE);

    // Saturation over five induced losses.
    for (int i = 1; i <= 5; i++) begin
      locked = 1'b0;
      wait_state(2'd0, 20, "sat_drop_timeout");
      check($sformatf("sat_loss_%0d", i), loss_count, (i < LMAX) ? i : LMAX);
      locked = 1'b1;
      wait_state(2'd1, 20, "sat_stab_timeout");
    end
    wait_state(2'd2, 20, "sat_run_timeout");
    check("sat_held", loss_count, LMAX);

    // Asynchronous reset between edges while in RUN.
    repeat (2) cycle();
    #3;
    reset = 1'b1;
    #1;
    check("async_sys_reset", sys_reset, 1);
    check("async_ready", ready, 0);
    check("async_loss", loss_count, 0);
    check("async_state", state_dbg, 0);
    cycle();
    reset = 1'b0;
    repeat (5) cycle();
    check("async_no_early_release", sys_reset, 1);
    wait_state(2'd2, 20, "async_rerun_timeout");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
